// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - two-stage radix-4 Booth multiplier with valid/ready handshake
// Optional feature: define MUL_PIPE_FLUSH_EN to add the flush input.
module mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MUL_PIPE_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sign,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  // Extended operand width, Booth digit count, product width, digit-multiple width
  localparam int EW  = WIDTH + 2;
  localparam int NPP = EW / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int MW  = EW + 1;

  logic flush_w;
`ifdef MUL_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Stage registers
  logic              s1_v_q, s1_v_d;
  logic              s2_v_q, s2_v_d;
  logic [PW-1:0]     s1_sum_q, s1_sum_d;
  logic [PW-1:0]     s1_carry_q, s1_carry_d;
  logic [PW-1:0]     s1_neg_q, s1_neg_d;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [PW-1:0]     s2_res_q, s2_res_d;
  logic [TAG_W-1:0]  s2_tag_q;

  // Handshake
  logic s2_load;
  logic s1_load;
  logic accept;

  assign s2_load  = ~s2_v_q | out_ready;
  assign s1_load  = ~s1_v_q | s2_load;
  assign in_ready = s1_load & ~reset & ~flush_w;
  assign accept   = in_valid & in_ready;

  // Operand extension: the top two bits repeat the sign only for signed operations,
  // so the extended values are always non-negative for unsigned inputs.
  logic [EW-1:0] a_ext;
  logic [EW:0]   b_pad;

  assign a_ext = {{2{in_sign & in_a[WIDTH-1]}}, in_a};
  assign b_pad = {{2{in_sign & in_b[WIDTH-1]}}, in_b, 1'b0};

  // Booth partial products; negation is ones' complement here, the +1 rides in s1_neg_d
  logic [PW-1:0] pp [NPP];
  logic [2:0]    trip;
  logic          one;
  logic          two;
  logic [MW-1:0] mag;
  logic [MW-1:0] row;

  // Radix-4 Booth recode of the multiplier and selection of each digit multiple
  always_comb begin
    s1_neg_d = '0;
    trip     = '0;
    one      = 1'b0;
    two      = 1'b0;
    mag      = '0;
    row      = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_pad[2*i +: 3];
      one  = trip[1] ^ trip[0];
      two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
      if (one) begin
        mag = {a_ext[EW-1], a_ext};
      end else if (two) begin
        mag = {a_ext, 1'b0};
      end else begin
        mag = '0;
      end
      row = trip[2] ? ~mag : mag;
      pp[i] = {{(PW-MW){row[MW-1]}}, row} << (2*i);
      s1_neg_d[2*i] = trip[2];
    end
  end

  // Carry-save reduction of all partial products to one sum/carry pair (mod 2^PW)
  logic [PW-1:0] csa_s;
  logic [PW-1:0] csa_c;

  always_comb begin
    s1_sum_d   = pp[0];
    s1_carry_d = '0;
    csa_s      = '0;
    csa_c      = '0;
    for (int i = 1; i < NPP; i++) begin
      csa_s      = s1_sum_d ^ s1_carry_d ^ pp[i];
      csa_c      = ((s1_sum_d & s1_carry_d) | (s1_sum_d & pp[i]) | (s1_carry_d & pp[i])) << 1;
      s1_sum_d   = csa_s;
      s1_carry_d = csa_c;
    end
  end

  // Final carry-propagate add folds in the pending Booth +1 terms
  always_comb begin
    s2_res_d = s1_sum_q + s1_carry_q + s1_neg_q;
  end

  // Stage-valid next state: S2 drains into the consumer, S1 advances into S2
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (s2_load) begin
      s2_v_d = s1_v_q;
    end
    if (s1_load) begin
      s1_v_d = accept;
    end
    if (reset || flush_w) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  // Pipeline registers; flush only drops valid bits, reset also clears data
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s1_neg_q   <= '0;
      s1_tag_q   <= '0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (accept) begin
        s1_sum_q   <= s1_sum_d;
        s1_carry_q <= s1_carry_d;
        s1_neg_q   <= s1_neg_d;
        s1_tag_q   <= in_tag;
      end
      if (s2_load && s1_v_q && !flush_w) begin
        s2_res_q <= s2_res_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_v_q;
  assign out_result = s2_res_q;
  assign out_tag    = s2_tag_q;
  assign busy       = s1_v_q | s2_v_q;

endmodule
